// File: rtl/status_array_write_arbiter_if.sv
// Port bundle for the status-array write arbiter: initializer beats, runtime
// update handshake and the registered SRAM write port.
interface status_array_write_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int ROW_WIDTH  = 8,
  parameter int NUM_BLOCKS = 4
);
  logic                  i_halt;
  logic [ADDR_WIDTH-1:0] i_init_addr;
  logic [ROW_WIDTH-1:0]  i_init_data;
  logic                  i_init_wen;
  logic [NUM_BLOCKS-1:0] i_init_wmask;
  logic                  i_init_valid;
  logic                  i_init_complete;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [ROW_WIDTH-1:0]  i_req_data;
  logic [NUM_BLOCKS-1:0] i_req_wmask;
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [ROW_WIDTH-1:0]  o_data;
  logic                  o_wen;
  logic [NUM_BLOCKS-1:0] o_wmask;
  logic                  o_valid;
  logic                  o_run;

  modport master (
    output i_halt, i_init_addr, i_init_data, i_init_wen, i_init_wmask, i_init_valid,
           i_init_complete, i_req_addr, i_req_data, i_req_wmask, i_req_valid,
    input  o_req_ready, o_addr, o_data, o_wen, o_wmask, o_valid, o_run
  );

  modport slave (
    input  i_halt, i_init_addr, i_init_data, i_init_wen, i_init_wmask, i_init_valid,
           i_init_complete, i_req_addr, i_req_data, i_req_wmask, i_req_valid,
    output o_req_ready, o_addr, o_data, o_wen, o_wmask, o_valid, o_run
  );
endinterface

// File: rtl/status_array_write_arbiter.sv
// Sole status-SRAM write port: forwards initializer zeroing beats in INIT,
// then drains runtime status updates through a 2-entry FIFO in RUN.
module status_array_write_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int ROW_WIDTH  = 8,
  parameter int NUM_BLOCKS = 4
) (
  input  logic                         clk,
  input  logic                         arst,
  status_array_write_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_r;
  logic [1:0]            count_r;
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [ADDR_WIDTH-1:0] fifo_addr_r  [2];
  logic [ROW_WIDTH-1:0]  fifo_data_r  [2];
  logic [NUM_BLOCKS-1:0] fifo_wmask_r [2];

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ROW_WIDTH-1:0]  data_r;
  logic                  wen_r;
  logic [NUM_BLOCKS-1:0] wmask_r;
  logic                  valid_r;

  logic                  run_s;
  logic                  req_ready_s;
  logic                  push_s;
  logic                  pop_s;

  // Handshake and FIFO strobes; push/pop only on an edge that stays in RUN.
  always_comb begin
    run_s       = (state_r == ST_RUN);
    req_ready_s = run_s & ~bus.i_halt & (count_r < 2'd2);
    push_s      = req_ready_s & bus.i_req_valid & bus.i_init_complete;
    pop_s       = run_s & ~bus.i_halt & bus.i_init_complete & (count_r != 2'd0);
  end

  // FIFO storage: payload only, occupancy is tracked in the control block.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r]  <= bus.i_req_addr;
      fifo_data_r[wr_ptr_r]  <= bus.i_req_data;
      fifo_wmask_r[wr_ptr_r] <= bus.i_req_wmask;
    end
  end

  // Mode FSM, FIFO pointers/count and the registered SRAM port.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_r  <= ST_INIT;
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      data_r   <= {ROW_WIDTH{1'b0}};
      wen_r    <= 1'b0;
      wmask_r  <= {NUM_BLOCKS{1'b0}};
      valid_r  <= 1'b0;
    end else if (!bus.i_halt) begin
      case (state_r)
        ST_INIT: begin
          addr_r  <= bus.i_init_addr;
          data_r  <= bus.i_init_data;
          wen_r   <= bus.i_init_wen;
          wmask_r <= bus.i_init_wmask;
          valid_r <= bus.i_init_valid;
          if (bus.i_init_complete) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!bus.i_init_complete) begin
            // Re-entering INIT: anything still queued is stale and dropped.
            state_r  <= ST_INIT;
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            addr_r   <= bus.i_init_addr;
            data_r   <= bus.i_init_data;
            wen_r    <= bus.i_init_wen;
            wmask_r  <= bus.i_init_wmask;
            valid_r  <= bus.i_init_valid;
          end else begin
            if (pop_s) begin
              addr_r   <= fifo_addr_r[rd_ptr_r];
              data_r   <= fifo_data_r[rd_ptr_r];
              wmask_r  <= fifo_wmask_r[rd_ptr_r];
              wen_r    <= 1'b1;
              valid_r  <= 1'b1;
              rd_ptr_r <= ~rd_ptr_r;
            end else begin
              wen_r    <= 1'b0;
              valid_r  <= 1'b0;
            end
            if (push_s) begin
              wr_ptr_r <= ~wr_ptr_r;
            end
            case ({push_s, pop_s})
              2'b10:   count_r <= count_r + 2'd1;
              2'b01:   count_r <= count_r - 2'd1;
              default: count_r <= count_r;
            endcase
          end
        end
        default: begin
          state_r  <= ST_INIT;
          count_r  <= 2'd0;
          wr_ptr_r <= 1'b0;
          rd_ptr_r <= 1'b0;
          wen_r    <= 1'b0;
          valid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_addr      = addr_r;
  assign bus.o_data      = data_r;
  assign bus.o_wen       = wen_r;
  assign bus.o_wmask     = wmask_r;
  assign bus.o_valid     = valid_r;
  assign bus.o_run       = run_s;
  assign bus.o_req_ready = req_ready_s;

endmodule

// File: tb/tb_status_array_write_arbiter.sv
// Directed bench for status_array_write_arbiter: queue-based reference model
// compared every negedge, plus hand-computed expectations per scenario.
module tb_status_array_write_arbiter;

  logic clk  = 1'b0;
  logic arst = 1'b0;

  status_array_write_arbiter_if #(.ADDR_WIDTH(6), .ROW_WIDTH(8), .NUM_BLOCKS(4)) bus ();

  status_array_write_arbiter #(.ADDR_WIDTH(6), .ROW_WIDTH(8), .NUM_BLOCKS(4)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode flag plus a queue of pending updates (capacity 2).
  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
    logic [3:0] m;
  } req_t;

  req_t       q[$];
  bit         m_run   = 1'b0;
  logic [5:0] m_addr  = 6'd0;
  logic [7:0] m_data  = 8'd0;
  logic       m_wen   = 1'b0;
  logic [3:0] m_wmask = 4'd0;
  logic       m_valid = 1'b0;

  task automatic model_load_init();
    m_addr  = bus.i_init_addr;
    m_data  = bus.i_init_data;
    m_wen   = bus.i_init_wen;
    m_wmask = bus.i_init_wmask;
    m_valid = bus.i_init_valid;
  endtask

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_run = 1'b0; q.delete();
      m_addr = 6'd0; m_data = 8'd0; m_wen = 1'b0; m_wmask = 4'd0; m_valid = 1'b0;
    end else if (!bus.i_halt) begin
      if (!m_run) begin
        model_load_init();
        if (bus.i_init_complete) m_run = 1'b1;
      end else if (!bus.i_init_complete) begin
        model_load_init();
        q.delete();
        m_run = 1'b0;
      end else begin
        bit   accept;
        req_t r;
        accept = bus.i_req_valid && (q.size() < 2);
        if (q.size() > 0) begin
          r = q.pop_front();
          m_addr = r.a; m_data = r.d; m_wmask = r.m; m_wen = 1'b1; m_valid = 1'b1;
        end else begin
          m_wen = 1'b0; m_valid = 1'b0;
        end
        if (accept) q.push_back({bus.i_req_addr, bus.i_req_data, bus.i_req_wmask});
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_addr",  {26'd0, bus.o_addr},  {26'd0, m_addr});
      check("m_data",  {24'd0, bus.o_data},  {24'd0, m_data});
      check("m_wen",   {31'd0, bus.o_wen},   {31'd0, m_wen});
      check("m_wmask", {28'd0, bus.o_wmask}, {28'd0, m_wmask});
      check("m_valid", {31'd0, bus.o_valid}, {31'd0, m_valid});
      check("m_run",   {31'd0, bus.o_run},   {31'd0, m_run});
      check("m_ready", {31'd0, bus.o_req_ready},
            {31'd0, (m_run && !bus.i_halt && q.size() < 2)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [5:0] a, input logic [7:0] d, input logic [3:0] m);
    bus.i_req_valid = v; bus.i_req_addr = a; bus.i_req_data = d; bus.i_req_wmask = m;
  endtask

  task automatic set_init(input logic v, input logic w, input logic [5:0] a, input logic [7:0] d,
                          input logic [3:0] m);
    bus.i_init_valid = v; bus.i_init_wen = w; bus.i_init_addr = a;
    bus.i_init_data = d; bus.i_init_wmask = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_halt = 1'b0;
    bus.i_init_complete = 1'b0;
    set_init(1'b0, 1'b0, 6'd0, 8'd0, 4'd0);
    set_req(1'b0, 6'd0, 8'd0, 4'd0);
    #1 arst = 1'b1;
    #2 chk_en = 1'b1;
    check("rst_addr",  {26'd0, bus.o_addr}, 32'd0);
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.o_req_ready}, 32'd0);
    check("rst_run",   {31'd0, bus.o_run}, 32'd0);
    tick();
    #2 arst = 1'b0;

    // Init pass-through of a zeroing sweep
    for (int i = 0; i < 64; i++) begin
      set_init(1'b1, 1'b1, i[5:0], 8'h00, 4'hF);
      tick();
      check("init_addr", {26'd0, bus.o_addr}, i);
      check("init_wen",  {31'd0, bus.o_wen}, 32'd1);
      check("init_ready", {31'd0, bus.o_req_ready}, 32'd0);
    end
    bus.i_init_complete = 1'b1;
    set_init(1'b0, 1'b0, 6'd0, 8'd0, 4'd0);
    tick();
    check("run_on",    {31'd0, bus.o_run}, 32'd1);
    check("run_ready", {31'd0, bus.o_req_ready}, 32'd1);
    tick();

    // Single update latency
    set_req(1'b1, 6'h2A, 8'hC3, 4'b0101);
    tick();
    set_req(1'b0, 6'd0, 8'd0, 4'd0);
    check("lat_e0_valid", {31'd0, bus.o_valid}, 32'd0);
    tick();
    check("lat_valid", {31'd0, bus.o_valid}, 32'd1);
    check("lat_addr",  {26'd0, bus.o_addr}, 32'h2A);
    check("lat_data",  {24'd0, bus.o_data}, 32'hC3);
    check("lat_wmask", {28'd0, bus.o_wmask}, 32'h5);
    tick();
    check("lat_valid_off", {31'd0, bus.o_valid}, 32'd0);

    // Back-to-back updates
    for (int i = 1; i <= 4; i++) begin
      set_req(1'b1, i[5:0], 8'h10 + i[7:0], 4'hA);
      check("b2b_ready", {31'd0, bus.o_req_ready}, 32'd1);
      tick();
      if (i > 1) check("b2b_addr", {26'd0, bus.o_addr}, i - 1);
    end
    set_req(1'b0, 6'd0, 8'd0, 4'd0);
    tick();
    check("b2b_last_addr",  {26'd0, bus.o_addr}, 32'd4);
    check("b2b_last_valid", {31'd0, bus.o_valid}, 32'd1);
    tick();
    check("b2b_idle", {31'd0, bus.o_valid}, 32'd0);

    // Halt with one entry queued
    set_req(1'b1, 6'h11, 8'h5A, 4'h3);
    tick();
    bus.i_halt = 1'b1;
    set_req(1'b1, 6'h12, 8'hA5, 4'hC);
    #1;
    check("halt_ready", {31'd0, bus.o_req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_addr",  {26'd0, bus.o_addr}, 32'h04);
      check("halt_valid", {31'd0, bus.o_valid}, 32'd0);
    end
    bus.i_halt = 1'b0;
    set_req(1'b0, 6'd0, 8'd0, 4'd0);
    tick();
    check("unhalt_addr",  {26'd0, bus.o_addr}, 32'h11);
    check("unhalt_data",  {24'd0, bus.o_data}, 32'h5A);
    check("unhalt_valid", {31'd0, bus.o_valid}, 32'd1);
    tick();

    // Re-entry into INIT with a queued and an in-flight update
    set_req(1'b1, 6'h3E, 8'hEE, 4'hF);
    tick();
    set_req(1'b1, 6'h3F, 8'hFF, 4'hF);
    bus.i_init_complete = 1'b0;
    set_init(1'b1, 1'b1, 6'h05, 8'h00, 4'hF);
    tick();
    set_req(1'b0, 6'd0, 8'd0, 4'd0);
    check("reinit_run",  {31'd0, bus.o_run}, 32'd0);
    check("reinit_addr", {26'd0, bus.o_addr}, 32'h05);
    check("reinit_ready", {31'd0, bus.o_req_ready}, 32'd0);
    set_init(1'b1, 1'b1, 6'h06, 8'h00, 4'hF);
    tick();
    check("reinit_next", {26'd0, bus.o_addr}, 32'h06);
    tick();
    check("reinit_no_stale", {26'd0, bus.o_addr}, 32'h06);

    // Asynchronous reset with an update pending
    bus.i_init_complete = 1'b1;
    set_init(1'b0, 1'b0, 6'd0, 8'd0, 4'd0);
    tick();
    set_req(1'b1, 6'h21, 8'h77, 4'h9);
    tick();
    set_req(1'b0, 6'd0, 8'd0, 4'd0);
    bus.i_init_complete = 1'b0;
    #2 arst = 1'b1;
    #1;
    check("arst_addr",  {26'd0, bus.o_addr}, 32'd0);
    check("arst_wmask", {28'd0, bus.o_wmask}, 32'd0);
    check("arst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("arst_ready", {31'd0, bus.o_req_ready}, 32'd0);
    tick();
    #2 arst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_valid", {31'd0, bus.o_valid}, 32'd0);
      check("post_rst_addr",  {26'd0, bus.o_addr}, 32'd0);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
